conv_engine_param: RTL and testbench

Parametrised 2-D valid-convolution engine, the successor to the fixed 4x4-filter / 4x16-image convolution datapath. It replaces the fixed counters with a self-sequencing controller driven by a start/done handshake. Image, filter, stride, filter count and output scaling are all configurable. The block sits between the shared word memory and the top-level controller.

---
 rtl/conv_engine_param.sv | 219 +++++++++++++++++++++
 tb/tb_conv_engine_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_engine_param.sv
// Parametrised 2-D valid-convolution engine: loads the image once, then for each filter
// loads its coefficients, runs one MAC per cycle per window and packs scaled results into words.
module conv_engine_param #(
  parameter int DW     = 8,
  parameter int BPW    = 4,
  parameter int AW     = 8,
  parameter int K      = 4,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 4,
  parameter int STRIDE = 1,
  parameter int NF     = 1,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [AW-1:0]     img_base,
  input  logic [AW-1:0]     filt_base,
  input  logic [AW-1:0]     res_base,
  output logic [AW-1:0]     mem_rd_addr,
  input  logic [BPW*DW-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [AW-1:0]     mem_wr_addr,
  output logic [BPW*DW-1:0] mem_wr_data,
  output logic              busy,
  output logic              done
);
  localparam int OW   = (IMG_W - K) / STRIDE + 1;
  localparam int OH   = (IMG_H - K) / STRIDE + 1;
  localparam int NO   = OH * OW;
  localparam int RW   = (NO + BPW - 1) / BPW;
  localparam int KK   = K * K;
  localparam int FWRD = KK / BPW;
  localparam int IWRD = IMG_H * IMG_W / BPW;
  localparam int WW   = BPW * DW;
  localparam int ACCW = 2 * DW + $clog2(KK);
  localparam int CW   = $clog2(IWRD + KK + NO + NF + 4) + 1;
  localparam int IBW  = $clog2(IWRD * WW);
  localparam int FBW  = $clog2(FWRD * WW);
  localparam int PBW  = $clog2(WW);

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] IWRD_C = CW'(IWRD);
  localparam logic [CW-1:0] FWRD_C = CW'(FWRD);
  localparam logic [CW-1:0] KK_C   = CW'(KK);
  localparam logic [CW-1:0] NO_C   = CW'(NO);
  localparam logic [CW-1:0] NO1_C  = CW'(NO - 1);
  localparam logic [CW-1:0] K1_C   = CW'(K - 1);
  localparam logic [CW-1:0] OW1_C  = CW'(OW - 1);
  localparam logic [CW-1:0] BPW1_C = CW'(BPW - 1);
  localparam logic [CW-1:0] NF1_C  = CW'(NF - 1);

  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_F, COMPUTE, WRITE, DONE} state_t;
  state_t state, state_nx;

  logic [AW-1:0]      img_base_q, filt_base_q, res_base_q;
  logic               mode_q;
  logic [CW-1:0]      ld_cnt, mac_cnt, fr, fc, win_r, win_c, out_idx, lane, w_cnt, f_cnt;
  logic [ACCW-1:0]    acc;
  logic [WW-1:0]      pack;
  logic [IWRD*WW-1:0] img_buf;
  logic [FWRD*WW-1:0] filt_buf;

  logic               mac_done, out_last, lane_full;
  logic [31:0]        pix_idx;
  logic [IBW-1:0]     pix_bit;
  logic [DW-1:0]      pix, coef, out_byte;
  logic [2*DW-1:0]    prod;
  logic [ACCW-1:0]    scaled;

  assign mac_done  = (mac_cnt == KK_C);
  assign out_last  = (out_idx == NO1_C);
  assign lane_full = (lane == BPW1_C);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    // NOTE: a default is assigned before the case so no path can infer a latch.
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD_I;
      LOAD_I:  if (ld_cnt == IWRD_C) state_nx = LOAD_F;
      LOAD_F:  if (ld_cnt == FWRD_C) state_nx = COMPUTE;
      COMPUTE: if (mac_done && (lane_full || out_last)) state_nx = WRITE;
      WRITE: begin
        if (out_idx == NO_C) state_nx = (f_cnt == NF1_C) ? DONE : LOAD_F;
        else                 state_nx = COMPUTE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (state == LOAD_I && ld_cnt != IWRD_C)
      mem_rd_addr = img_base_q + AW'(ld_cnt);
    if (state == LOAD_F && ld_cnt != FWRD_C)
      mem_rd_addr = filt_base_q + AW'(32'(f_cnt) * FWRD + 32'(ld_cnt));
    if (state == WRITE) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = res_base_q + AW'(32'(f_cnt) * RW + 32'(w_cnt));
      mem_wr_data = pack;
    end
  end

  // Element under the current filter tap; indices past the window during commit are unused.
  always_comb begin
    pix_idx  = (32'(win_r) * STRIDE + 32'(fr)) * IMG_W + 32'(win_c) * STRIDE + 32'(fc);
    pix_bit  = IBW'(pix_idx * DW);
    pix      = img_buf[pix_bit +: DW];
    coef     = filt_buf[FBW'(32'(mac_cnt) * DW) +: DW];
    prod     = pix * coef;
    scaled   = acc >> SHIFT;
    out_byte = scaled[DW-1:0];
    if (mode_q && (scaled >> DW) != '0) out_byte = '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_base_q  <= '0;
      filt_base_q <= '0;
      res_base_q  <= '0;
      mode_q      <= 1'b0;
      ld_cnt      <= '0;
      mac_cnt     <= '0;
      fr          <= '0;
      fc          <= '0;
      win_r       <= '0;
      win_c       <= '0;
      out_idx     <= '0;
      lane        <= '0;
      w_cnt       <= '0;
      f_cnt       <= '0;
      acc         <= '0;
      pack        <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q      <= mode;
          img_base_q  <= img_base;
          filt_base_q <= filt_base;
          res_base_q  <= res_base;
          ld_cnt      <= '0;
          f_cnt       <= '0;
        end
        LOAD_I: ld_cnt <= (ld_cnt == IWRD_C) ? '0 : ld_cnt + ONE;
        LOAD_F: begin
          if (ld_cnt == FWRD_C) begin
            ld_cnt  <= '0;
            mac_cnt <= '0;
            fr      <= '0;
            fc      <= '0;
            win_r   <= '0;
            win_c   <= '0;
            out_idx <= '0;
            lane    <= '0;
            w_cnt   <= '0;
            acc     <= '0;
            pack    <= '0;
          end else begin
            ld_cnt <= ld_cnt + ONE;
          end
        end
        COMPUTE: begin
          if (!mac_done) begin
            acc     <= acc + ACCW'(prod);
            mac_cnt <= mac_cnt + ONE;
            if (fc == K1_C) begin
              fc <= '0;
              fr <= fr + ONE;
            end else begin
              fc <= fc + ONE;
            end
          end else begin
            pack[PBW'(32'(lane) * DW) +: DW] <= out_byte;
            acc     <= '0;
            mac_cnt <= '0;
            fr      <= '0;
            fc      <= '0;
            out_idx <= out_idx + ONE;
            lane    <= lane_full ? '0 : lane + ONE;
            if (win_c == OW1_C) begin
              win_c <= '0;
              win_r <= win_r + ONE;
            end else begin
              win_c <= win_c + ONE;
            end
          end
        end
        WRITE: begin
          pack  <= '0;
          w_cnt <= w_cnt + ONE;
          if (out_idx == NO_C && f_cnt != NF1_C) f_cnt <= f_cnt + ONE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: buffers carry no reset; every run reloads them fully before any read.
  always_ff @(posedge clk) begin
    if (state == LOAD_I && ld_cnt != '0)
      img_buf[IBW'((32'(ld_cnt) - 1) * WW) +: WW] <= mem_rd_data;
    if (state == LOAD_F && ld_cnt != '0)
      filt_buf[FBW'((32'(ld_cnt) - 1) * WW) +: WW] <= mem_rd_data;
  end

endmodule

// File: tb/tb_conv_engine_param.sv
// Scoreboard bench for conv_engine_param: three instances (default, STRIDE=2, NF=2)
// share one word memory; expected writes are queued by stimulus and popped by a monitor.
module tb_conv_engine_param;
  localparam int NDUT = 3;
  localparam logic [7:0] IMG  = 8'h40;
  localparam logic [7:0] FILT = 8'h80;

  logic clk = 1'b0;
  logic rst;
  logic mode;
  logic [7:0] img_base, filt_base, res_base;
  logic [NDUT-1:0] start_v;
  wire  [NDUT-1:0] busy_v, done_v, wr_en_v;
  wire  [7:0]  rd_addr [NDUT];
  logic [31:0] rd_data [NDUT];
  wire  [7:0]  wr_addr [NDUT];
  wire  [31:0] wr_data [NDUT];
  logic [31:0] mem [256];

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int img_reads = 0;

  always #5 clk = ~clk;

  conv_engine_param u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode),
    .img_base(img_base), .filt_base(filt_base), .res_base(res_base),
    .mem_rd_addr(rd_addr[0]), .mem_rd_data(rd_data[0]),
    .mem_wr_en(wr_en_v[0]), .mem_wr_addr(wr_addr[0]), .mem_wr_data(wr_data[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  conv_engine_param #(.STRIDE(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode),
    .img_base(img_base), .filt_base(filt_base), .res_base(res_base),
    .mem_rd_addr(rd_addr[1]), .mem_rd_data(rd_data[1]),
    .mem_wr_en(wr_en_v[1]), .mem_wr_addr(wr_addr[1]), .mem_wr_data(wr_data[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  conv_engine_param #(.NF(2)) u_dut_nf2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode),
    .img_base(img_base), .filt_base(filt_base), .res_base(res_base),
    .mem_rd_addr(rd_addr[2]), .mem_rd_data(rd_data[2]),
    .mem_wr_en(wr_en_v[2]), .mem_wr_addr(wr_addr[2]), .mem_wr_data(wr_data[2]),
    .busy(busy_v[2]), .done(done_v[2])
  );

  // Synchronous-read memory: data appears the cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) rd_data[i] <= mem[rd_addr[i]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    for (int i = 0; i < NDUT; i++) begin
      if (wr_en_v[i]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write dut%0d: addr 0x%0h data 0x%0h, no write expected",
                   i, wr_addr[i], wr_data[i]);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("wr_addr dut%0d", i), {24'h0, wr_addr[i]}, {24'h0, e.addr});
          check($sformatf("wr_data dut%0d @0x%0h", i, e.addr), wr_data[i], e.data);
        end
      end
    end
    if (busy_v[2] && rd_addr[2] >= IMG && rd_addr[2] < IMG + 8'd16) img_reads++;
  end

  task automatic fill(input logic [7:0] base, input int n, input logic [31:0] w);
    for (int i = 0; i < n; i++) mem[base + 8'(i)] = w;
  endtask

  // 13 outputs of one byte value: three full words then one word with a single lane.
  task automatic exp_13(input logic [7:0] base, input logic [7:0] b);
    for (int i = 0; i < 3; i++) exp_q.push_back('{addr: base + 8'(i), data: {4{b}}});
    exp_q.push_back('{addr: base + 8'd3, data: {24'h0, b}});
  endtask

  task automatic run(input int d, input logic m, input logic [7:0] rb,
                     input int exp_cyc, input int extra_at, input string name);
    int cyc;
    @(negedge clk);
    mode = m;
    res_base = rb;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v = '0;
    cyc = 1;
    check({name, " busy_at_start"}, {31'h0, busy_v[d]}, 32'd1);
    while (!done_v[d] && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start_v[d] = (cyc == extra_at);
    end
    start_v = '0;
    check({name, " done_seen"}, {31'h0, done_v[d]}, 32'd1);
    check({name, " done_cycle"}, cyc, exp_cyc);
    check({name, " busy_with_done"}, {31'h0, busy_v[d]}, 32'd0);
    @(negedge clk);
    check({name, " done_one_cycle"}, {31'h0, done_v[d]}, 32'd0);
    repeat (3) @(negedge clk);
    check({name, " queue_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b0;
    start_v = '0;
    mode = 1'b0;
    img_base = IMG;
    filt_base = FILT;
    res_base = 8'h10;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'h0, busy_v[0]}, 32'd0);
    check("reset done", {31'h0, done_v[0]}, 32'd0);
    check("reset wr_en", {31'h0, wr_en_v[0]}, 32'd0);
    check("reset rd_addr", {24'h0, rd_addr[0]}, 32'd0);
    check("reset wr_addr", {24'h0, wr_addr[0]}, 32'd0);
    check("reset wr_data", wr_data[0], 32'd0);
    rst = 1'b1;

    // All ones: acc 16, output 1 per window.
    fill(IMG, 16, 32'h01010101);
    fill(FILT, 4, 32'h01010101);
    exp_13(8'h10, 8'h01);
    run(0, 1'b0, 8'h10, 248, 0, "ones");

    // All 0xFF: scaled 65025 -> truncate 0x01, saturate 0xFF; a second start mid-run is ignored.
    fill(IMG, 16, 32'hFFFFFFFF);
    fill(FILT, 4, 32'hFFFFFFFF);
    exp_13(8'h10, 8'h01);
    run(0, 1'b0, 8'h10, 248, 0, "ff_trunc");
    exp_13(8'h10, 8'hFF);
    run(0, 1'b1, 8'h10, 248, 100, "ff_sat");

    // STRIDE=2, element (r,c)=c: outputs 2c+1 for c=0..6.
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        mem[IMG + 8'(4 * r + j)] = {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
    fill(FILT, 4, 32'h01010101);
    exp_q.push_back('{addr: 8'h10, data: 32'h07050301});
    exp_q.push_back('{addr: 8'h11, data: 32'h000D0B09});
    run(1, 1'b0, 8'h10, 17 + 5 + 7 * 17 + 2 + 1, 0, "stride2");

    // NF=2: filter 0 all 1, filter 1 all 2; image loaded only once.
    fill(IMG, 16, 32'h01010101);
    fill(FILT, 4, 32'h01010101);
    fill(FILT + 8'd4, 4, 32'h02020202);
    exp_13(8'h10, 8'h01);
    exp_13(8'h14, 8'h02);
    img_reads = 0;
    run(2, 1'b0, 8'h10, 17 + 2 * (5 + 13 * 17 + 4) + 1, 0, "nf2");
    check("nf2 image_reads", img_reads, 32'd16);

    // Result base near the top of the address space wraps to 0x00, 0x01.
    fill(FILT, 4, 32'h01010101);
    exp_13(8'hFE, 8'h01);
    run(0, 1'b0, 8'hFE, 248, 0, "wrap");

    // Abort: extra start during LOAD_I, reset during COMPUTE, then a clean rerun.
    @(negedge clk);
    res_base = 8'h10;
    mode = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = '0;
    for (int cyc = 2; cyc <= 60; cyc++) begin
      @(negedge clk);
      start_v[0] = (cyc == 5);
    end
    start_v = '0;
    check("abort busy_before_rst", {31'h0, busy_v[0]}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort busy_in_rst", {31'h0, busy_v[0]}, 32'd0);
    check("abort wr_en_in_rst", {31'h0, wr_en_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (busy_v[0] || done_v[0]) seen = 1'b1;
    end
    check("abort stays_idle", {31'h0, seen}, 32'd0);
    check("abort no_pending", exp_q.size(), 32'd0);
    exp_13(8'h10, 8'h01);
    run(0, 1'b0, 8'h10, 248, 0, "rerun");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
